// File: rtl/uart_arb_pkg.sv
// Shared definitions for the UART output arbiter.
//   UART_NEWLINE : character that ends a line and releases a line lock
//   lock_state_e : line-lock FSM states
//   src_idx_w()  : width of a source index for a given number of sources
package uart_arb_pkg;

  localparam logic [7:0] UART_NEWLINE = 8'h0A;

  typedef enum logic {LOCK_IDLE, LOCK_HELD} lock_state_e;

  function automatic int unsigned src_idx_w(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/uart_src_fifo.sv
// Per-source character FIFO feeding the UART output arbiter.
// Pointers carry one extra wrap bit so full and empty are distinguishable
// without a separate occupancy counter.
// Ports:
//   clock, reset_n  : rising-edge clock, asynchronous active-low reset
//   push_i, din_i   : write request and character (ignored when full)
//   pop_i           : read request (ignored when empty)
//   dout_o          : character at the head of the FIFO
//   full_o, empty_o : occupancy flags, registered-state only
module uart_src_fifo #(
  parameter int unsigned DEPTH = 8
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       push_i,
  input  logic [7:0] din_i,
  input  logic       pop_i,
  output logic [7:0] dout_o,
  output logic       full_o,
  output logic       empty_o
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [AW:0] wptr_q, wptr_d;
  logic [AW:0] rptr_q, rptr_d;
  logic [7:0]  mem_q [DEPTH];
  logic        do_push, do_pop;

  assign full_o  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign empty_o = (wptr_q == rptr_q);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign dout_o  = mem_q[rptr_q[AW-1:0]];

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    if (do_push) wptr_d = wptr_q + 1'b1;
    if (do_pop)  rptr_d = rptr_q + 1'b1;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

  // Storage needs no reset: the pointers alone define what is valid.
  always_ff @(posedge clock) begin
    if (do_push) mem_q[wptr_q[AW-1:0]] <= din_i;
  end

endmodule

// File: rtl/uart_out_arbiter.sv
// Merges several character producers into one registered UART output
// stream. Each source writes into its own FIFO; a round-robin scheduler
// pops one FIFO head per cycle into the output register.
// Optional feature macro: UART_LINE_LOCK_EN -- once a source emits a
// non-newline character it owns the output until it emits a newline or
// stays idle for LOCK_TIMEOUT cycles, so lines never interleave.
// Ports:
//   clock, reset_n       : rising-edge clock, asynchronous active-low reset
//   in_valid, in_ch      : per-source character offers (8 bits per source)
//   in_ready             : per-source accept (FIFO not full)
//   uart_out_valid/ch/src: registered output character and its source index
//   uart_out_ready       : sink accept
module uart_out_arbiter
  import uart_arb_pkg::*;
#(
  parameter int unsigned N_SRC        = 4,
  parameter int unsigned FIFO_DEPTH   = 8,
  parameter int unsigned LOCK_TIMEOUT = 64
) (
  input  logic                        clock,
  input  logic                        reset_n,
  input  logic [N_SRC-1:0]            in_valid,
  input  logic [N_SRC*8-1:0]          in_ch,
  output logic [N_SRC-1:0]            in_ready,
  output logic                        uart_out_valid,
  output logic [7:0]                  uart_out_ch,
  output logic [src_idx_w(N_SRC)-1:0] uart_out_src,
  input  logic                        uart_out_ready
);

  localparam int unsigned SW = src_idx_w(N_SRC);

  if (N_SRC < 2 || N_SRC > 16 || FIFO_DEPTH < 2 ||
      (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || LOCK_TIMEOUT == 0) begin : g_param_chk
    $error("uart_out_arbiter: illegal parameter combination");
  end

  logic [N_SRC-1:0] full, empty, push, pop, elig;
  logic [7:0]       head [N_SRC];

  logic          gnt_vld, load, do_pop;
  logic [SW-1:0] gnt_idx;
  logic [7:0]    gnt_ch;

  logic          out_vld_q, out_vld_d;
  logic [7:0]    out_ch_q, out_ch_d;
  logic [SW-1:0] out_src_q, out_src_d;
  logic [SW-1:0] last_q, last_d;

  // in_ready looks only at registered occupancy, never at this cycle's pop.
  assign in_ready = ~full;
  assign push     = in_valid & ~full;

  for (genvar i = 0; i < N_SRC; i++) begin : g_src
    uart_src_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clock   (clock),
      .reset_n (reset_n),
      .push_i  (push[i]),
      .din_i   (in_ch[8*i +: 8]),
      .pop_i   (pop[i]),
      .dout_o  (head[i]),
      .full_o  (full[i]),
      .empty_o (empty[i])
    );
  end

`ifdef UART_LINE_LOCK_EN
  localparam int unsigned TW = $clog2(LOCK_TIMEOUT + 1);

  lock_state_e   state_q, state_d;
  logic [SW-1:0] owner_q, owner_d;
  logic [TW-1:0] tmo_q, tmo_d;

  always_comb begin
    elig = ~empty;
    if (state_q == LOCK_HELD) begin
      elig          = '0;
      elig[owner_q] = ~empty[owner_q];
    end
  end
`else
  assign elig = ~empty;
`endif

  // Search starts one past the last winner, so every source gets a turn.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = last_q;
    for (int k = 1; k <= int'(N_SRC); k++) begin
      if (!gnt_vld && elig[SW'((int'(last_q) + k) % int'(N_SRC))]) begin
        gnt_vld = 1'b1;
        gnt_idx = SW'((int'(last_q) + k) % int'(N_SRC));
      end
    end
  end

  assign gnt_ch = head[gnt_idx];
  assign load   = !out_vld_q || uart_out_ready;
  assign do_pop = load && gnt_vld;

  always_comb begin
    pop = '0;
    if (do_pop) pop[gnt_idx] = 1'b1;
  end

  always_comb begin
    out_vld_d = out_vld_q;
    out_ch_d  = out_ch_q;
    out_src_d = out_src_q;
    last_d    = last_q;
    if (load) begin
      out_vld_d = gnt_vld;
      if (gnt_vld) begin
        out_ch_d  = gnt_ch;
        out_src_d = gnt_idx;
        last_d    = gnt_idx;
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      out_vld_q <= 1'b0;
      out_ch_q  <= '0;
      out_src_q <= '0;
      last_q    <= SW'(N_SRC - 1);
    end else begin
      out_vld_q <= out_vld_d;
      out_ch_q  <= out_ch_d;
      out_src_q <= out_src_d;
      last_q    <= last_d;
    end
  end

  assign uart_out_valid = out_vld_q;
  assign uart_out_ch    = out_ch_q;
  assign uart_out_src   = out_src_q;

`ifdef UART_LINE_LOCK_EN
  // While held, only the owner can be granted, so any pop is the owner's.
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    tmo_d   = tmo_q;
    case (state_q)
      LOCK_IDLE: begin
        if (do_pop && gnt_ch != UART_NEWLINE) begin
          state_d = LOCK_HELD;
          owner_d = gnt_idx;
          tmo_d   = '0;
        end
      end
      LOCK_HELD: begin
        if ((do_pop && gnt_ch == UART_NEWLINE) || tmo_q == TW'(LOCK_TIMEOUT)) begin
          state_d = LOCK_IDLE;
          tmo_d   = '0;
        end else if (push[owner_q] || !empty[owner_q]) begin
          tmo_d = '0;
        end else if (tmo_q != TW'(LOCK_TIMEOUT)) begin
          tmo_d = tmo_q + TW'(1);
        end
      end
      default: state_d = LOCK_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= LOCK_IDLE;
      owner_q <= '0;
      tmo_q   <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      tmo_q   <= tmo_d;
    end
  end
`endif

endmodule

// File: tb/tb_uart_out_arbiter.sv
// Self-checking bench for uart_out_arbiter (N_SRC=4, FIFO_DEPTH=8,
// LOCK_TIMEOUT=64). Line-lock scenarios are compiled in only when
// UART_LINE_LOCK_EN is defined.
module tb_uart_out_arbiter;

  localparam int unsigned N_SRC        = 4;
  localparam int unsigned FIFO_DEPTH   = 8;
  localparam int unsigned LOCK_TIMEOUT = 64;

  logic        clock = 1'b0;
  logic        reset_n;
  logic [3:0]  in_valid;
  logic [31:0] in_ch;
  logic [3:0]  in_ready;
  logic        uart_out_valid;
  logic [7:0]  uart_out_ch;
  logic [1:0]  uart_out_src;
  logic        uart_out_ready;

  always #5 clock = ~clock;

  uart_out_arbiter #(
    .N_SRC        (N_SRC),
    .FIFO_DEPTH   (FIFO_DEPTH),
    .LOCK_TIMEOUT (LOCK_TIMEOUT)
  ) dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .in_valid       (in_valid),
    .in_ch          (in_ch),
    .in_ready       (in_ready),
    .uart_out_valid (uart_out_valid),
    .uart_out_ch    (uart_out_ch),
    .uart_out_src   (uart_out_src),
    .uart_out_ready (uart_out_ready)
  );

  typedef struct packed {logic [1:0] src; logic [7:0] ch;} exp_t;
  typedef struct {logic [1:0] src; logic [7:0] ch; int t;} cap_t;

  exp_t exp_q[$];
  cap_t cap_q[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_errors = 0;
  int   cyc      = 0;
  int   n_out    = 0;
  bit   sb_en    = 1'b1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  always @(posedge clock) cyc <= cyc + 1;

  // A character is consumed at the next rising edge when valid && ready.
  always @(negedge clock) begin
    if (reset_n && uart_out_valid && uart_out_ready) begin
      n_out++;
      if (sb_en) begin
        if (exp_q.size() == 0) begin
          chk("sb_extra_output_queue_size", 32'(exp_q.size()), 32'd1);
        end else begin
          mon_e = exp_q.pop_front();
          chk("sb_ch", 32'(uart_out_ch), 32'(mon_e.ch));
          chk("sb_src", 32'(uart_out_src), 32'(mon_e.src));
        end
      end else begin
        cap_q.push_back('{uart_out_src, uart_out_ch, cyc});
      end
    end
  end

  task automatic drive(input logic [3:0] m, input logic [31:0] c);
    @(negedge clock);
    in_valid = m;
    in_ch    = c;
  endtask

  task automatic idle();
    @(negedge clock);
    in_valid = '0;
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset_n  = 1'b0;
    in_valid = '0;
    exp_q.delete();
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
  endtask

  task automatic drain(input string tag, input int budget);
    for (int i = 0; i < budget && exp_q.size() != 0; i++) @(negedge clock);
    chk(tag, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n0;
    int gap;
    reset_n        = 1'b0;
    in_valid       = 4'hF;
    in_ch          = '0;
    uart_out_ready = 1'b1;

    // Reset holds everything quiet even with all sources offering.
    repeat (3) @(negedge clock);
    chk("rst_out_valid", 32'(uart_out_valid), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'hF);
    chk("rst_out_ch", 32'(uart_out_ch), 32'd0);
    chk("rst_out_src", 32'(uart_out_src), 32'd0);
    in_valid = '0;
    @(negedge clock);
    reset_n = 1'b1;

    // Single push: output valid one edge after the push edge.
    drive(4'b0001, 32'h0000_0041);
    exp_q.push_back('{2'd0, 8'h41});
    idle();
    @(negedge clock);
    chk("lat_valid", 32'(uart_out_valid), 32'd1);
    chk("lat_ch", 32'(uart_out_ch), 32'h41);
    chk("lat_src", 32'(uart_out_src), 32'd0);
    drain("drain_latency", 20);

    // Round-robin from reset (last = 3): a, b, c, d.
    do_reset();
    drive(4'hF, {8'h64, 8'h63, 8'h62, 8'h61});
    exp_q.push_back('{2'd0, 8'h61});
    exp_q.push_back('{2'd1, 8'h62});
    exp_q.push_back('{2'd2, 8'h63});
    exp_q.push_back('{2'd3, 8'h64});
    idle();
    drain("drain_round_robin", 600);

    // Backpressure: one char in the output register plus 8 in the FIFO.
    do_reset();
    uart_out_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      drive(4'b0010, {16'h0, 8'(48 + i), 8'h0});
      if (i == 8) chk("full_ready_before_last", 32'(in_ready[1]), 32'd1);
      if (i == 9) chk("full_ready_dropped", 32'(in_ready[1]), 32'd0);
      if (i < 9) exp_q.push_back('{2'd1, 8'(48 + i)});
    end
    idle();
    repeat (3) @(negedge clock);
    chk("hold_valid", 32'(uart_out_valid), 32'd1);
    chk("hold_ch", 32'(uart_out_ch), 32'h30);
    chk("hold_src", 32'(uart_out_src), 32'd1);
    @(posedge clock);
    #1 uart_out_ready = 1'b1;
    drain("drain_full", 600);

    // Reset asserted between edges while characters are buffered.
    do_reset();
    uart_out_ready = 1'b0;
    for (int i = 0; i < 5; i++) drive(4'b0100, {8'h0, 8'(80 + i), 16'h0});
    idle();
    repeat (2) @(negedge clock);
    chk("pre_rst_valid", 32'(uart_out_valid), 32'd1);
    #2 reset_n = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(uart_out_valid), 32'd0);
    chk("mid_rst_ch", 32'(uart_out_ch), 32'd0);
    chk("mid_rst_src", 32'(uart_out_src), 32'd0);
    chk("mid_rst_in_ready", 32'(in_ready), 32'hF);
    exp_q.delete();
    @(negedge clock);
    reset_n = 1'b1;
    @(posedge clock);
    #1 uart_out_ready = 1'b1;
    n0 = n_out;
    repeat (12) @(negedge clock);
    chk("post_rst_no_stale", 32'(n_out - n0), 32'd0);

`ifdef UART_LINE_LOCK_EN
    // Line lock: "hi\n" from source 0 is not split by source 2's stream.
    do_reset();
    sb_en = 1'b0;
    cap_q.delete();
    drive(4'b0101, {8'h0, 8'h78, 8'h0, 8'h68});
    drive(4'b0101, {8'h0, 8'h78, 8'h0, 8'h69});
    drive(4'b0101, {8'h0, 8'h78, 8'h0, 8'h0A});
    drive(4'b0100, {8'h0, 8'h78, 16'h0});
    repeat (20) @(negedge clock);
    in_valid = '0;
    repeat (40) @(negedge clock);
    chk("lock_out_count", 32'(cap_q.size() >= 4), 32'd1);
    if (cap_q.size() >= 4) begin
      chk("lock_c0", 32'(cap_q[0].ch), 32'h68);
      chk("lock_c1", 32'(cap_q[1].ch), 32'h69);
      chk("lock_c2", 32'(cap_q[2].ch), 32'h0A);
      chk("lock_c3", 32'(cap_q[3].ch), 32'h78);
      chk("lock_c3_src", 32'(cap_q[3].src), 32'd2);
    end

    // Lock timeout: source 1 waits for the idle owner to time out.
    do_reset();
    cap_q.delete();
    drive(4'b0011, {16'h0, 8'h79, 8'h68});
    idle();
    for (int i = 0; i < 200 && cap_q.size() < 2; i++) @(negedge clock);
    chk("tmo_out_count", 32'(cap_q.size() >= 2), 32'd1);
    if (cap_q.size() >= 2) begin
      gap = cap_q[1].t - cap_q[0].t;
      chk("tmo_first_ch", 32'(cap_q[0].ch), 32'h68);
      chk("tmo_second_ch", 32'(cap_q[1].ch), 32'h79);
      chk("tmo_second_src", 32'(cap_q[1].src), 32'd1);
      chk("tmo_gap_at_least_timeout", 32'(gap >= 64), 32'd1);
      chk("tmo_gap_bounded", 32'(gap <= 72), 32'd1);
    end
    sb_en = 1'b1;
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
